// File: rtl/display_scan_if.sv
// Handshake and pin bundle between the multiplier result path
// and the seven-segment scan controller.
interface display_scan_if;
    logic       load;
    logic [7:0] product;
    logic       busy;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output load, product,
        input  busy, an, seg, dp
    );

    modport slave (
        input  load, product,
        output busy, an, seg, dp
    );
endinterface

// File: rtl/display_scan_controller.sv
// Latches a signed product, converts its magnitude to BCD by
// double-dabble and scans sign/hundreds/tens/units onto 4 anodes.
module display_scan_controller #(
    parameter int REFRESH_DIV   = 100000,
    parameter bit BLANK_LEADING = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    display_scan_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [6:0] BLANK = 7'b1111111;
    localparam logic [6:0] MINUS = 7'b0111111;

    state_t        state;
    logic [7:0]    mag;
    logic [11:0]   bcd;
    logic [11:0]   bcd_adj;
    logic [3:0]    cnt;
    logic          neg_s;
    logic          busy_q;
    logic [3:0]    units;
    logic [3:0]    tens;
    logic [3:0]    hund;
    logic          neg;
    logic [CW-1:0] rcnt;
    logic [1:0]    idx;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0011000;
            default: s = 7'b0000110;
        endcase
        return s;
    endfunction

    assign bcd_adj = {add3(bcd[11:8]), add3(bcd[7:4]), add3(bcd[3:0])};

    // Shadow registers convert in the background; the committed
    // digits change only in COMMIT so no partial value is displayed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            mag    <= '0;
            bcd    <= '0;
            cnt    <= '0;
            neg_s  <= 1'b0;
            units  <= '0;
            tens   <= '0;
            hund   <= '0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.load) begin
                        neg_s  <= bus.product[7];
                        mag    <= bus.product[7] ? (~bus.product + 8'd1)
                                                 : bus.product;
                        bcd    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt == 4'd8) begin
                        state <= COMMIT;
                    end else begin
                        {bcd, mag} <= {bcd_adj[10:0], mag, 1'b0};
                        cnt        <= cnt + 4'd1;
                    end
                end
                COMMIT: begin
                    hund   <= bcd[11:8];
                    tens   <= bcd[7:4];
                    units  <= bcd[3:0];
                    neg    <= neg_s;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
            idx  <= '0;
        end else if (rcnt == CW'(REFRESH_DIV - 1)) begin
            rcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            rcnt <= rcnt + CW'(1);
        end
    end

    always_comb begin
        bus.an  = 4'b1110;
        bus.seg = BLANK;
        unique case (1'b1)
            (idx == 2'd0): begin
                bus.an  = 4'b1110;
                bus.seg = enc(units);
            end
            (idx == 2'd1): begin
                bus.an  = 4'b1101;
                bus.seg = (BLANK_LEADING && hund == 4'd0 && tens == 4'd0)
                          ? BLANK : enc(tens);
            end
            (idx == 2'd2): begin
                bus.an  = 4'b1011;
                bus.seg = (BLANK_LEADING && hund == 4'd0)
                          ? BLANK : enc(hund);
            end
            (idx == 2'd3): begin
                bus.an  = 4'b0111;
                bus.seg = (neg && |{hund, tens, units}) ? MINUS : BLANK;
            end
        endcase
    end

    assign bus.busy = busy_q;
    assign bus.dp   = 1'b1;
endmodule

// File: tb/tb_display_scan_controller.sv
// Directed table-driven bench: two instances (leading-zero blanking
// on and off) driven with identical loads and scanned digit by digit.
module tb_display_scan_controller;
    logic clk = 1'b0;
    logic rst;
    int   ntests = 0;
    int   nfail  = 0;

    display_scan_if ia();
    display_scan_if ib();

    display_scan_controller #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia)
    );

    display_scan_controller #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]      p;
        logic [3:0][6:0] ea;
        logic [3:0][6:0] eb;
    } vec_t;

    vec_t            vecs[10];
    logic [3:0][6:0] prev_a;

    function automatic int an_idx(input logic [3:0] an);
        case (an)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return 0;
        endcase
    endfunction

    task automatic drive(input logic l, input logic [7:0] p);
        ia.load = l; ia.product = p;
        ib.load = l; ib.product = p;
    endtask

    task automatic do_load(input logic [7:0] p, input bit second,
                           input logic [7:0] p2);
        int n;
        @(negedge clk);
        drive(1'b1, p);
        @(negedge clk);
        drive(1'b0, p);
        n = 0;
        while (ia.busy && n < 20) begin
            if (second && n == 2) drive(1'b1, p2);
            else if (second && n == 3) drive(1'b0, p2);
            ntests++;
            if (ia.an == 4'b1110 || ia.an == 4'b1101 ||
                ia.an == 4'b1011 || ia.an == 4'b0111) begin
                if (ia.seg !== prev_a[an_idx(ia.an)]) begin
                    nfail++;
                    $display("FAIL hold_old p=%h an=%b seg=%b want %b",
                             p, ia.an, ia.seg, prev_a[an_idx(ia.an)]);
                end
            end else begin
                nfail++;
                $display("FAIL onehot an=%b", ia.an);
            end
            n++;
            @(negedge clk);
        end
        ntests++;
        if (n != 10) begin
            nfail++;
            $display("FAIL busy_len p=%h got %0d want 10", p, n);
        end
        ntests++;
        if (ib.busy !== 1'b0) begin
            nfail++;
            $display("FAIL busy_b p=%h got %b want 0", p, ib.busy);
        end
    endtask

    task automatic chk_digits(input logic [7:0] p,
                              input logic [3:0][6:0] ea,
                              input logic [3:0][6:0] eb);
        logic [3:0] want;
        int n;
        for (int d = 0; d < 4; d++) begin
            want = ~(4'b0001 << d);
            n = 0;
            while (ia.an !== want && n < 40) begin
                @(negedge clk); n++;
            end
            ntests++;
            if (ia.an !== want || ia.seg !== ea[d] || ia.dp !== 1'b1) begin
                nfail++;
                $display("FAIL dig_a p=%h d=%0d an=%b seg=%b dp=%b want %b %b 1",
                         p, d, ia.an, ia.seg, ia.dp, want, ea[d]);
            end
            n = 0;
            while (ib.an !== want && n < 40) begin
                @(negedge clk); n++;
            end
            ntests++;
            if (ib.an !== want || ib.seg !== eb[d]) begin
                nfail++;
                $display("FAIL dig_b p=%h d=%0d an=%b seg=%b want %b %b",
                         p, d, ib.an, ib.seg, want, eb[d]);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [7:0] got,
                       input logic [7:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got %b want %b", nm, got, exp);
        end
    endtask

    initial begin
        // {sign, hundreds, tens, units}
        vecs[0] = '{8'd42,  {7'h7F, 7'h7F, 7'h19, 7'h24},
                            {7'h7F, 7'h40, 7'h19, 7'h24}};
        vecs[1] = '{8'h80,  {7'h3F, 7'h79, 7'h24, 7'h00},
                            {7'h3F, 7'h79, 7'h24, 7'h00}};
        vecs[2] = '{8'd0,   {7'h7F, 7'h7F, 7'h7F, 7'h40},
                            {7'h7F, 7'h40, 7'h40, 7'h40}};
        vecs[3] = '{8'd5,   {7'h7F, 7'h7F, 7'h7F, 7'h12},
                            {7'h7F, 7'h40, 7'h40, 7'h12}};
        vecs[4] = '{8'd127, {7'h7F, 7'h79, 7'h24, 7'h78},
                            {7'h7F, 7'h79, 7'h24, 7'h78}};
        vecs[5] = '{8'hFF,  {7'h3F, 7'h7F, 7'h7F, 7'h79},
                            {7'h3F, 7'h40, 7'h40, 7'h79}};
        vecs[6] = '{8'd100, {7'h7F, 7'h79, 7'h40, 7'h40},
                            {7'h7F, 7'h79, 7'h40, 7'h40}};
        vecs[7] = '{8'h97,  {7'h3F, 7'h79, 7'h40, 7'h12},
                            {7'h3F, 7'h79, 7'h40, 7'h12}};
        vecs[8] = '{8'hE2,  {7'h3F, 7'h7F, 7'h30, 7'h40},
                            {7'h3F, 7'h40, 7'h30, 7'h40}};
        vecs[9] = '{8'd69,  {7'h7F, 7'h7F, 7'h02, 7'h18},
                            {7'h7F, 7'h40, 7'h02, 7'h18}};

        rst = 1'b1;
        drive(1'b0, 8'd0);
        repeat (2) @(negedge clk);
        chk("rst_busy", {7'd0, ia.busy}, 8'd0);
        chk("rst_an",   {4'd0, ia.an},   8'h0E);
        chk("rst_seg",  {1'b0, ia.seg},  8'h40);
        chk("rst_dp",   {7'd0, ia.dp},   8'd1);
        rst = 1'b0;
        prev_a = {7'h7F, 7'h7F, 7'h7F, 7'h40};

        for (int i = 0; i < 10; i++) begin
            do_load(vecs[i].p, 1'b0, 8'd0);
            chk_digits(vecs[i].p, vecs[i].ea, vecs[i].eb);
            prev_a = vecs[i].ea;
        end

        // second load three cycles into a conversion must be dropped
        do_load(8'd7, 1'b1, 8'd99);
        chk_digits(8'd7, {7'h7F, 7'h7F, 7'h7F, 7'h78},
                         {7'h7F, 7'h40, 7'h40, 7'h78});

        // asynchronous reset in the middle of a conversion
        @(negedge clk);
        drive(1'b1, 8'hE2);
        @(negedge clk);
        drive(1'b0, 8'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_busy",  {7'd0, ia.busy}, 8'd0);
        chk("mid_an",    {4'd0, ia.an},   8'h0E);
        chk("mid_seg",   {1'b0, ia.seg},  8'h40);
        chk("mid_dp",    {7'd0, ia.dp},   8'd1);
        chk("mid_seg_b", {1'b0, ib.seg},  8'h40);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_an0",  {4'd0, ia.an},   8'h0E);
        @(negedge clk);
        chk("post_an1",  {4'd0, ia.an},   8'h0D);
        chk("post_seg1", {1'b0, ia.seg},  8'h7F);
        chk("post_seg1b", {1'b0, ib.seg}, 8'h40);

        prev_a = {7'h7F, 7'h7F, 7'h7F, 7'h40};
        do_load(vecs[0].p, 1'b0, 8'd0);
        chk_digits(vecs[0].p, vecs[0].ea, vecs[0].eb);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
